// File: rtl/imem_responder.sv
// imem_responder: fixed-latency big-endian word memory with Rd/Wr/Stall/Done handshake
module imem_responder #(
  parameter int LATENCY = 2,
  parameter int MEM_ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr_In,
  input  logic [15:0] DataIn_In,
  input  logic        Rd_In,
  input  logic        Wr_In,
  output logic [15:0] DataOut_Out,
  output logic        Stall_Out,
  output logic        Done_Out,
  output logic        err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [MEM_ADDR_W-1:0] a, a_lo;
  logic [15:0] d;
  logic wr;
  logic valid, take, done;
  logic [7:0] mem [2**MEM_ADDR_W];
  assign a_lo = {a[MEM_ADDR_W-1:1], 1'b1};
  // accept/reject decode, countdown and outputs; rst masks every output
  always_comb begin
    valid = (Rd_In ^ Wr_In) && !Addr_In[0];
    take = !rst && state == IDLE && valid;
    done = !rst && state == BUSY && cnt == 4'd0;
    state_n = state == IDLE ? (valid ? BUSY : IDLE) : (cnt == 4'd0 ? IDLE : BUSY);
    cnt_n = state == IDLE ? (valid ? 4'(LATENCY - 1) : cnt) : (cnt == 4'd0 ? cnt : cnt - 4'd1);
    Stall_Out = take || (!rst && state == BUSY && cnt != 4'd0);
    Done_Out = done;
    err = !rst && state == IDLE && (Rd_In || Wr_In) && !valid;
    DataOut_Out = done && !wr ? {mem[a], mem[a_lo]} : 16'h0000;
  end
  // state, request latch and array; the write lands on the edge ending the Done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      for (int i = 0; i < 2**MEM_ADDR_W; i++) mem[i] <= 8'h00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (take) begin
        a <= Addr_In[MEM_ADDR_W-1:0];
        d <= DataIn_In;
        wr <= Wr_In;
      end
      if (done && wr) begin
        mem[a] <= d[15:8];
        mem[a_lo] <= d[7:0];
      end
    end
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Multi-cycle memory responder that services word read/write requests from the fetch stage (and, reused, from the memory stage) over a Rd/Wr/Stall/Done handshake. It holds a byte-addressed, big-endian array and completes each accepted request after a fixed, parameterised latency. While a request is in flight it asserts Stall so the requester freezes its PC and pipeline. Its fixed-latency behaviour replaces the single-cycle memory model so that stall handling in the pipeline can be exercised.

## Interface
- LATENCY, 2, cycles from request acceptance to Done; legal range 1..15.
- MEM_ADDR_W, 10, byte-address bits actually decoded; array size is 2^MEM_ADDR_W bytes.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Addr_In  in  16  byte address of the request; bit 0 must be 0.
- DataIn_In  in  16  write data, used only when Wr_In is high.
- Rd_In  in  1  read request.
- Wr_In  in  1  write request.
- DataOut_Out  out  16  read data; valid only while Done_Out is high, otherwise 16'h0000.
- Stall_Out  out  1  high while a request is being accepted or is in flight.
- Done_Out  out  1  one-cycle pulse marking completion of the accepted request.
- err  out  1  high for one cycle when a request is rejected.

## Operation
- Two states: IDLE and BUSY. A 4-bit countdown counter `cnt` is held internally.
- Addresses are taken modulo 2^MEM_ADDR_W.
- Storage is big-endian: byte A holds bits [15:8] and byte A+1 holds bits [7:0].

**IDLE**
- A request is valid when exactly one of Rd_In and Wr_In is high and Addr_In[0] = 0.
- On a valid request, the block latches Addr_In, DataIn_In and the operation.
- In that same cycle, Stall_Out = 1 combinationally.
- Next state: BUSY with cnt = LATENCY-1.

**Rejected requests (IDLE only)**
- A request is rejected when Rd_In and Wr_In are both high, or when either is high with Addr_In[0] = 1.
- On rejection, err = 1 combinationally that cycle. Stall_Out stays 0, no state change, no memory access.
- Rd_In = Wr_In = 0 means no activity; all outputs are 0.

**BUSY**
- While cnt != 0: Stall_Out = 1, Done_Out = 0, and cnt decrements.
- When cnt == 0 (the Done cycle): Stall_Out = 0 and Done_Out = 1.
  - Read: DataOut_Out = {mem[a], mem[a+1]} for the latched address a.
  - Write: {mem[a], mem[a+1]} ← latched data on the edge ending the Done cycle; DataOut_Out = 0.
  - Next state: IDLE.
- Inputs are ignored while in BUSY; the latched request is the one serviced. err is never asserted in BUSY.

**Reset**
- rst forces IDLE, cnt = 0, and clears the whole array to 0.
- rst overrides everything, including mid-operation: the in-flight request is dropped, no Done is produced and no write is performed.
- Reset output values: DataOut_Out = 0, Stall_Out = 0, Done_Out = 0, err = 0.

## Timing
- Request accepted in cycle T.
- Stall_Out is high in cycles T .. T+LATENCY-1.
- Done_Out is high in cycle T+LATENCY only.
- A new request can be accepted no earlier than cycle T+LATENCY+1, so peak throughput is one operation per LATENCY+1 cycles.
- LATENCY = 1: stall is high in T only, and Done occurs in T+1.
- A write completing in cycle D is visible to a read accepted at D+1 or later.
- Requester rule: hold Rd/Wr/Addr/Data until Done. The block does not depend on this, because it latches at acceptance.
- Wrap-around: Addr_In = 16'hFFFE with MEM_ADDR_W = 10 accesses bytes 0x3FE and 0x3FF. Addresses 0x0400 and 0x0000 alias.

## Test plan
- **Reset then read:** rst for 2 cycles, then Rd at 0x0010 (LATENCY = 2).
  - Required: Stall high at T and T+1; Done at T+2 with DataOut 0x0000.
- **Write then read:** Wr 0x0020 ← 0xBEEF, wait for Done, then Rd 0x0020.
  - Required: Done with DataOut 0xBEEF; bytes 0x20 = 0xBE and 0x21 = 0xEF.
- **Rejected requests:**
  - Rd at 0x0011: err = 1 for one cycle, Stall = 0, and the state stays IDLE.
  - Rd and Wr both high: err = 1, and no write occurs (verified by a later read returning the old value).
- **Inputs changed mid-flight:** accept Rd at 0x0020, then change Addr_In to 0x0030 during BUSY.
  - Required: Done returns the data at 0x0020; err never asserts.
- **Reset mid-operation:** accept Wr 0x0040 ← 0x1234, assert rst in cycle T+1.
  - Required: no Done pulse; a subsequent read of 0x0040 returns 0x0000.
- **Latency sweep and wrap-around:** LATENCY = 1 and LATENCY = 15, back-to-back reads.
  - Required: Done exactly LATENCY cycles after acceptance; gap between acceptances is LATENCY+1.
  - Wr at 0xFFFE ← 0xA5A5, then Rd at 0x03FE returns 0xA5A5.
